// File: rtl/driver_cmd_pkg.sv
// Shared encodings for the driver command issuer: opcodes, FSM states, CFG bit map.
package driver_cmd_pkg;

    typedef enum logic [1:0] {
        OP_MEM_WR = 2'd0,
        OP_DOT_WR = 2'd1,
        OP_SEL_WR = 2'd2,
        OP_CFG    = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    // CFG command: cmd_data[5:3] mask, [2] row/col, [1] inverter, [0] output active
    localparam int CFG_ACTIVE_BIT = 0;
    localparam int CFG_INV_BIT    = 1;
    localparam int CFG_RC_BIT     = 2;
    localparam int CFG_MASK_LSB   = 3;
    localparam int CFG_MASK_W     = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/driver_cmd_issuer_if.sv
// Host command handshake bundle (valid/ready plus command fields).
interface driver_cmd_issuer_if #(
    parameter int MAL = 6
);
    logic           cmd_valid;
    logic           cmd_ready;
    logic [1:0]     cmd_op;
    logic [MAL-1:0] cmd_addr;
    logic [MAL-1:0] cmd_row;
    logic [MAL-1:0] cmd_col;
    logic [15:0]    cmd_data;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_row, cmd_col, cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_row, cmd_col, cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/driver_cmd_fifo.sv
// Generic synchronous FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module driver_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [LW-1:0]    o_level
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][WIDTH-1:0] r_mem;
    logic [PW-1:0]               r_wr_ptr;
    logic [PW-1:0]               r_rd_ptr;
    logic [LW-1:0]               r_level;
    logic                        w_push;
    logic                        w_pop;

    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_dout  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
        end
    end
endmodule

// File: rtl/driver_cmd_issuer.sv
// Turns valid/ready commands into setup/strobe/hold bus sequences for the driver core.
// Optional DRIVER_CMD_FIFO_EN puts a 4-entry in-order command FIFO in front of the FSM.
module driver_cmd_issuer
    import driver_cmd_pkg::*;
#(
    parameter int MEM_ADDRESS_LENGTH = 6,
    parameter int SETUP_CYC          = 3,
    parameter int STROBE_CYC         = 4,
    parameter int HOLD_CYC           = 3
) (
    input  logic                          clock,
    input  logic                          reset_n,
    driver_cmd_issuer_if.slave            cmd,
    output logic                          busy,
    output logic [MEM_ADDRESS_LENGTH-1:0] mem_address_a,
    output logic [MEM_ADDRESS_LENGTH-1:0] mem_sel_col_address_a,
    output logic [MEM_ADDRESS_LENGTH-1:0] row_select_a,
    output logic [MEM_ADDRESS_LENGTH-1:0] col_select_a,
    output logic [15:0]                   data_in_a,
    output logic                          mem_write_n_a,
    output logic                          mem_dot_write_n_a,
    output logic                          mem_sel_write_n_a,
    output logic [2:0]                    mask_select_a,
    output logic                          row_col_select_a,
    output logic                          inverter_select_a,
`ifdef DRIVER_CMD_FIFO_EN
    output logic [2:0]                    cmd_fifo_level,
`endif
    output logic                          output_active_a
);
    localparam int MAL   = MEM_ADDRESS_LENGTH;
    localparam int CMD_W = 2 + 3 * MAL + 16;
    localparam int CNT_W = $clog2(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC) + 1);
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

    if (SETUP_CYC < 1 || STROBE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_param
        $error("driver_cmd_issuer: SETUP_CYC, STROBE_CYC and HOLD_CYC must all be >= 1");
    end

    state_e           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    op_e              r_op;
    logic             w_take;
    logic [CMD_W-1:0] w_in_cmd;
    logic [CMD_W-1:0] w_cmd;
    op_e              w_op;
    logic [MAL-1:0]   w_addr, w_row, w_col;
    logic [15:0]      w_data;

    assign w_in_cmd = {cmd.cmd_op, cmd.cmd_addr, cmd.cmd_row, cmd.cmd_col, cmd.cmd_data};
    assign {w_op, w_addr, w_row, w_col, w_data} = w_cmd;

`ifdef DRIVER_CMD_FIFO_EN
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [CMD_W-1:0] w_fifo_dout;

    driver_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (4)
    ) u_fifo (
        .clk     (clock),
        .rst_n   (reset_n),
        .i_push  (cmd.cmd_valid),
        .i_din   (w_in_cmd),
        .i_pop   (w_take),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (cmd_fifo_level)
    );

    // CFG goes through the FIFO too, so it can never overtake a queued write.
    assign cmd.cmd_ready = !w_fifo_full;
    assign w_take        = (r_state == ST_IDLE) && !w_fifo_empty;
    assign w_cmd         = w_fifo_dout;
`else
    assign cmd.cmd_ready = (r_state == ST_IDLE);
    assign w_take        = cmd.cmd_valid && (r_state == ST_IDLE);
    assign w_cmd         = w_in_cmd;
`endif

    assign busy = (r_state != ST_IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= OP_MEM_WR;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_take && w_op != OP_CFG) r_op <= w_op;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = (r_cnt != '0) ? r_cnt - CNT_W'(1) : r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_take && w_op != OP_CFG) begin
                    w_state_nxt = ST_SETUP;
                    w_cnt_nxt   = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_STROBE;
                    w_cnt_nxt   = STROBE_LD;
                end
            end
            ST_STROBE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = HOLD_LD;
                end
            end
            default: begin
                if (r_cnt == '0) w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Strobes are registered from the next state so they align exactly with STROBE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_write_n_a         <= 1'b1;
            mem_dot_write_n_a     <= 1'b1;
            mem_sel_write_n_a     <= 1'b1;
            mem_address_a         <= '0;
            mem_sel_col_address_a <= '0;
            row_select_a          <= '0;
            col_select_a          <= '0;
            data_in_a             <= '0;
            mask_select_a         <= '0;
            row_col_select_a      <= 1'b0;
            inverter_select_a     <= 1'b0;
            output_active_a       <= 1'b0;
        end else begin
            mem_write_n_a     <= !(w_state_nxt == ST_STROBE && r_op == OP_MEM_WR);
            mem_dot_write_n_a <= !(w_state_nxt == ST_STROBE && r_op == OP_DOT_WR);
            mem_sel_write_n_a <= !(w_state_nxt == ST_STROBE && r_op == OP_SEL_WR);
            if (w_take) begin
                case (w_op)
                    OP_MEM_WR: begin
                        mem_address_a <= w_addr;
                        data_in_a     <= w_data;
                    end
                    OP_DOT_WR: begin
                        row_select_a <= w_row;
                        col_select_a <= w_col;
                    end
                    OP_SEL_WR: begin
                        mem_sel_col_address_a <= w_addr;
                        data_in_a             <= w_data;
                    end
                    default: begin
                        mask_select_a     <= w_data[CFG_MASK_LSB +: CFG_MASK_W];
                        row_col_select_a  <= w_data[CFG_RC_BIT];
                        inverter_select_a <= w_data[CFG_INV_BIT];
                        output_active_a   <= w_data[CFG_ACTIVE_BIT];
                    end
                endcase
            end
        end
    end
endmodule
